gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_pkg.sv | 25 ++
 rtl/gpio_sync.sv | 23 ++
 rtl/gpio_irq_ctrl.sv | 144 ++++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: register indices,
// the register vector type and the debounce counter width.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_DATA_IN  = 3'd0,
    REG_RISE_EN  = 3'd1,
    REG_FALL_EN  = 3'd2,
    REG_PENDING  = 3'd3,
    REG_IRQ_MASK = 3'd4
  } reg_idx_e;

  localparam int unsigned GPIO_MAX   = 32;
  localparam int unsigned DBNC_CNT_W = 16;

  // Enable, mask and pending registers share the full bus width; bits at or
  // above N_GPIO are held at zero by the controller.
  typedef logic [GPIO_MAX-1:0] gpio_vec_t;

  // Set has priority over a simultaneous write-one-to-clear.
  function automatic gpio_vec_t w1c_apply(gpio_vec_t cur, gpio_vec_t clr, gpio_vec_t set);
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, reset to zero.
module gpio_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO edge-detect interrupt controller with a small register file.
// Optional per-bit input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned N_GPIO          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_GPIO-1:0] gpio_in_i,
  input  logic              reg_we_i,
  input  logic              reg_re_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_rvalid_o,
  output logic              irq_o
);

  localparam gpio_vec_t VALID_MASK = gpio_vec_t'((64'd1 << N_GPIO) - 64'd1);

  logic [N_GPIO-1:0] sync_q;
  logic [N_GPIO-1:0] filt_q;
  logic [N_GPIO-1:0] prev_q;

  gpio_vec_t filt_vec, prev_vec, set_vec, clr_vec, wr_val, rd_mux;
  gpio_vec_t rise_en_q, fall_en_q, irq_mask_q, pending_q;
  gpio_vec_t rise_en_d, fall_en_d, irq_mask_d, pending_d;

  gpio_sync #(
    .WIDTH(N_GPIO)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (gpio_in_i),
    .q_o   (sync_q)
  );

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [DBNC_CNT_W-1:0] DBNC_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DBNC_CNT_W-1:0] dbnc_cnt_q [N_GPIO];

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < N_GPIO; i++) begin
        dbnc_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_GPIO; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          dbnc_cnt_q[i] <= '0;
        end else if (dbnc_cnt_q[i] == DBNC_LAST) begin
          filt_q[i]     <= sync_q[i];
          dbnc_cnt_q[i] <= '0;
        end else begin
          dbnc_cnt_q[i] <= dbnc_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam int unsigned dbnc_cycles_unused = DEBOUNCE_CYCLES;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '0;
    end else begin
      filt_q <= sync_q;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt_q;
    end
  end

  assign filt_vec = gpio_vec_t'(filt_q);
  assign prev_vec = gpio_vec_t'(prev_q);
  assign wr_val   = reg_wdata_i & VALID_MASK;

  assign set_vec = (filt_vec & ~prev_vec & rise_en_q) |
                   (~filt_vec & prev_vec & fall_en_q);

  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    clr_vec    = '0;
    if (reg_we_i) begin
      case (reg_idx_e'(reg_addr_i))
        REG_RISE_EN:  rise_en_d  = wr_val;
        REG_FALL_EN:  fall_en_d  = wr_val;
        REG_PENDING:  clr_vec    = wr_val;
        REG_IRQ_MASK: irq_mask_d = wr_val;
        default: ;
      endcase
    end
    pending_d = w1c_apply(pending_q, clr_vec, set_vec);
  end

  // Read mux sees current state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_mux = '0;
    case (reg_idx_e'(reg_addr_i))
      REG_DATA_IN:  rd_mux = filt_vec;
      REG_RISE_EN:  rd_mux = rise_en_q;
      REG_FALL_EN:  rd_mux = fall_en_q;
      REG_PENDING:  rd_mux = pending_q;
      REG_IRQ_MASK: rd_mux = irq_mask_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_mask_q   <= '0;
      pending_q    <= '0;
      reg_rdata_o  <= '0;
      reg_rvalid_o <= 1'b0;
    end else begin
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_mask_q   <= irq_mask_d;
      pending_q    <= pending_d;
      reg_rvalid_o <= reg_re_i;
      if (reg_re_i) begin
        reg_rdata_o <= rd_mux;
      end
    end
  end

  assign irq_o = |(pending_q & irq_mask_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: register table, directed corner
// sequences and a randomized run against a pin-history reference model.
module tb_gpio_irq_ctrl;
  import gpio_pkg::*;

`ifdef GPIO_DEBOUNCE_EN
  localparam int EXTRA = 15;
`else
  localparam int EXTRA = 0;
`endif
  localparam int SETTLE = 6 + EXTRA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gpio = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_irq_ctrl #(
    .N_GPIO(8),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .gpio_in_i    (gpio),
    .reg_we_i     (we),
    .reg_re_i     (re),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_rdata_o  (rdata),
    .reg_rvalid_o (rvalid),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    d = rdata;
  endtask

  // Reference model: filtered value lags pins by 3 clock samples; edges
  // between consecutive filtered samples set PENDING one cycle later.
  logic [7:0]  gh [5];
  logic [7:0]  m_rise, m_fall, m_mask, m_pend, m_set, m_clr;
  logic [31:0] exp_rd;
  bit          exp_rv;

  initial begin
    logic [31:0] d;

    // Reset values, sampled while reset is held
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Register access table
    tbl.push_back('{1'b1, REG_RISE_EN,  32'hFFFF_FFFF, 32'h0,  "w_rise"});
    tbl.push_back('{1'b0, REG_RISE_EN,  32'h0,         32'hFF, "r_rise_masked"});
    tbl.push_back('{1'b1, REG_FALL_EN,  32'hA5A5_A5A5, 32'h0,  "w_fall"});
    tbl.push_back('{1'b0, REG_FALL_EN,  32'h0,         32'hA5, "r_fall"});
    tbl.push_back('{1'b1, REG_IRQ_MASK, 32'h1234_5633, 32'h0,  "w_mask"});
    tbl.push_back('{1'b0, REG_IRQ_MASK, 32'h0,         32'h33, "r_mask"});
    tbl.push_back('{1'b0, REG_DATA_IN,  32'h0,         32'h0,  "r_datain"});
    tbl.push_back('{1'b1, REG_PENDING,  32'hFF,        32'h0,  "w_pend"});
    tbl.push_back('{1'b0, REG_PENDING,  32'h0,         32'h0,  "r_pend"});
    tbl.push_back('{1'b1, 3'd5,         32'hFFFF_FFFF, 32'h0,  "w_addr5"});
    tbl.push_back('{1'b0, 3'd5,         32'h0,         32'h0,  "r_addr5"});
    tbl.push_back('{1'b0, 3'd6,         32'h0,         32'h0,  "r_addr6"});
    tbl.push_back('{1'b0, 3'd7,         32'h0,         32'h0,  "r_addr7"});
    tbl.push_back('{1'b1, REG_RISE_EN,  32'h0,         32'h0,  "w_rise0"});
    tbl.push_back('{1'b0, REG_RISE_EN,  32'h0,         32'h0,  "r_rise0"});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].d);
      else begin
        rd(tbl[i].a, d);
        check(tbl[i].name, d, tbl[i].exp);
      end
    end
    check("tbl_irq", 32'(irq), 32'd0);

    // Same-cycle read and write returns the old value
    wr(REG_RISE_EN, 32'h03);
    @(negedge clk);
    we = 1'b1; re = 1'b1; addr = REG_RISE_EN; wdata = 32'h0C;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rw_same_rvalid", 32'(rvalid), 32'd1);
    check("rw_same_old", rdata, 32'h03);
    rd(REG_RISE_EN, d);
    check("rw_same_new", d, 32'h0C);

    // Rise on bit0: irq exactly four cycles after the pin change
    do_reset();
    wr(REG_RISE_EN, 32'h01);
    wr(REG_IRQ_MASK, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (3 + EXTRA) @(posedge clk);
    #1 check("lat_minus1_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1 check("lat_irq", 32'(irq), 32'd1);
    rd(REG_PENDING, d);
    check("lat_pend", d, 32'h01);

    // Fall on bit2, then W1C clears pending and irq
    gpio = '0;
    do_reset();
    wr(REG_FALL_EN, 32'h04);
    wr(REG_IRQ_MASK, 32'h04);
    @(negedge clk) gpio[2] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    rd(REG_PENDING, d);
    check("fall_no_rise", d, 32'h0);
    @(negedge clk) gpio[2] = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("fall_irq", 32'(irq), 32'd1);
    rd(REG_PENDING, d);
    check("fall_pend", d, 32'h04);
    wr(REG_PENDING, 32'h04);
    check("w1c_irq", 32'(irq), 32'd0);
    rd(REG_PENDING, d);
    check("w1c_pend", d, 32'h0);

    // New rise on bit0 in the same cycle as its W1C: set wins
    do_reset();
    wr(REG_RISE_EN, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    @(negedge clk) gpio[0] = 1'b0;
    repeat (SETTLE) @(negedge clk);
    rd(REG_PENDING, d);
    check("setwin_pre", d, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (2 + EXTRA) @(negedge clk);
    @(negedge clk);
    we = 1'b1; addr = REG_PENDING; wdata = 32'h01;
    @(negedge clk);
    we = 1'b0;
    rd(REG_PENDING, d);
    check("setwin_pend", d, 32'h01);
    wr(REG_PENDING, 32'h01);
    rd(REG_PENDING, d);
    check("w1c_alone", d, 32'h0);

    // Masked pending never raises irq
    gpio = '0;
    do_reset();
    wr(REG_RISE_EN, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    rd(REG_PENDING, d);
    check("masked_pend", d, 32'h01);
    check("masked_irq", 32'(irq), 32'd0);

    // Reset during a read with pending set
    gpio = '0;
    do_reset();
    wr(REG_RISE_EN, 32'h01);
    wr(REG_IRQ_MASK, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check("mid_pre_irq", 32'(irq), 32'd1);
    re = 1'b1; addr = REG_PENDING;
    @(posedge clk);
    #2;
    check("mid_pre_rvalid", 32'(rvalid), 32'd1);
    check("mid_pre_rdata", rdata, 32'h01);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    gpio = 8'hFF;
    @(negedge clk);
    @(negedge clk) re = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rvalid", 32'(rvalid), 32'd0);
    end
    repeat (SETTLE) @(negedge clk);
    rd(REG_PENDING, d);
    check("post_rst_no_pend", d, 32'h0);
    check("post_rst_irq", 32'(irq), 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    // Glitch shorter than the debounce window is swallowed
    gpio = '0;
    do_reset();
    wr(REG_RISE_EN, 32'h01);
    @(negedge clk) gpio[0] = 1'b1;
    repeat (10) @(negedge clk);
    gpio[0] = 1'b0;
    repeat (30) @(negedge clk);
    rd(REG_DATA_IN, d);
    check("glitch_datain", d, 32'h0);
    rd(REG_PENDING, d);
    check("glitch_pend", d, 32'h0);
    // A held level passes after the debounce window
    @(negedge clk) gpio[0] = 1'b1;
    repeat (13) @(negedge clk);
    rd(REG_DATA_IN, d);
    check("dbnc_early_datain", d, 32'h0);
    repeat (8) @(negedge clk);
    rd(REG_DATA_IN, d);
    check("dbnc_late_datain", d, 32'h01);
    rd(REG_PENDING, d);
    check("dbnc_pend", d, 32'h01);
`else
    // Randomized run against the pin-history model
    gpio = '0;
    do_reset();
    for (int j = 0; j < 5; j++) gh[j] = '0;
    m_rise = '0; m_fall = '0; m_mask = '0; m_pend = '0;
    exp_rv = 1'b0; exp_rd = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("rnd_irq", 32'(irq), 32'(|(m_pend & m_mask)));
      check("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv) check("rnd_rdata", rdata, exp_rd);
      if ($urandom_range(0, 3) == 0) gpio = 8'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      re    = ($urandom_range(0, 2) == 0);
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      @(posedge clk);
      for (int j = 4; j > 0; j--) gh[j] = gh[j-1];
      gh[0] = gpio;
      m_set = (m_rise & gh[3] & ~gh[4]) | (m_fall & ~gh[3] & gh[4]);
      exp_rv = re;
      if (re) begin
        case (addr)
          3'd0:    exp_rd = {24'd0, gh[3]};
          3'd1:    exp_rd = {24'd0, m_rise};
          3'd2:    exp_rd = {24'd0, m_fall};
          3'd3:    exp_rd = {24'd0, m_pend};
          3'd4:    exp_rd = {24'd0, m_mask};
          default: exp_rd = 32'd0;
        endcase
      end
      m_clr = '0;
      if (we) begin
        case (addr)
          3'd1:    m_rise = wdata[7:0];
          3'd2:    m_fall = wdata[7:0];
          3'd3:    m_clr  = wdata[7:0];
          3'd4:    m_mask = wdata[7:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~m_clr) | m_set;
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rnd_final_irq", 32'(irq), 32'(|(m_pend & m_mask)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
